// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the iterative EX-stage ALU.
//   - operation codes (legacy 4-bit codes zero-extended, RV32M codes in 10xxx)
//   - FSM state enum used by alu_iterative
//   - calc_shw(): shift-amount width derived from the operand width
// No ports. The RV32M family is only decoded when ALU_MULDIV_EN is defined.
package alu_pkg;

    localparam logic [4:0] OpAnd    = 5'b00000;
    localparam logic [4:0] OpOr     = 5'b00001;
    localparam logic [4:0] OpAdd    = 5'b00010;
    localparam logic [4:0] OpSll    = 5'b00011;
    localparam logic [4:0] OpSlt    = 5'b00100;
    localparam logic [4:0] OpSltu   = 5'b00101;
    localparam logic [4:0] OpSub    = 5'b00110;
    localparam logic [4:0] OpXor    = 5'b00111;
    localparam logic [4:0] OpSrl    = 5'b01000;
    localparam logic [4:0] OpSra    = 5'b01001;
    localparam logic [4:0] OpMul    = 5'b10000;
    localparam logic [4:0] OpMulh   = 5'b10001;
    localparam logic [4:0] OpMulhsu = 5'b10010;
    localparam logic [4:0] OpMulhu  = 5'b10011;
    localparam logic [4:0] OpDiv    = 5'b10100;
    localparam logic [4:0] OpDivu   = 5'b10101;
    localparam logic [4:0] OpRem    = 5'b10110;
    localparam logic [4:0] OpRemu   = 5'b10111;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } alu_state_e;

    function automatic int unsigned calc_shw(input int unsigned xlen);
        return $clog2(xlen);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle multiply / restoring divide engine.
// Latches operand magnitudes and result signs on start, runs XLEN iterations,
// and raises done in the cycle of the last iteration together with the final,
// sign-corrected result (computed from the last iteration's next state).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           abandon the running operation (counter cleared)
//   start           load operands and begin iterating
//   is_div          1 = DIV/DIVU/REM/REMU, 0 = MUL/MULH/MULHSU/MULHU
//   sub_op[1:0]     low two op-code bits selecting the variant
//   op_a, op_b      operands (dividend/divisor for division)
//   done            last iteration happens this cycle
//   result          final result, valid while done is high
// Only instantiated when ALU_MULDIV_EN is defined.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            start,
    input  logic            is_div,
    input  logic [1:0]      sub_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = calc_shw(XLEN) + 1;

    logic            sgn_a, sgn_b, neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;

    // Multiply: prod_q = {partial high, multiplier being shifted out}.
    // Divide:   prod_q = {partial remainder, dividend/quotient}.
    logic [2*XLEN-1:0] prod_q, prod_n, full;
    logic [XLEN-1:0]   opnd_q;
    logic [CW-1:0]     cnt_q;
    logic              is_div_q, neg_lo_q, neg_hi_q;
    logic [1:0]        sub_q;

    logic [XLEN:0]     sum, shifted;
    logic [XLEN-1:0]   diff, quo, rem;

    always_comb begin
        if (is_div) begin
            sgn_a = !sub_op[0];
            sgn_b = !sub_op[0];
        end else begin
            sgn_a = (sub_op == 2'b01) || (sub_op == 2'b10);
            sgn_b = (sub_op == 2'b01);
        end
        neg_a = sgn_a & op_a[XLEN-1];
        neg_b = sgn_b & op_b[XLEN-1];
        mag_a = neg_a ? -op_a : op_a;
        mag_b = neg_b ? -op_b : op_b;
    end

    always_comb begin
        sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        // Remainder after a successful subtract is below the divisor, so XLEN bits suffice.
        diff    = shifted[XLEN-1:0] - opnd_q;
        if (is_div_q) begin
            if (shifted >= {1'b0, opnd_q}) begin
                prod_n = {diff, prod_q[XLEN-2:0], 1'b1};
            end else begin
                prod_n = {shifted[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
            end
        end else begin
            prod_n = {sum, prod_q[XLEN-1:1]};
        end
    end

    always_comb begin
        full = neg_lo_q ? -prod_n : prod_n;
        quo  = neg_lo_q ? -prod_n[XLEN-1:0] : prod_n[XLEN-1:0];
        rem  = neg_hi_q ? -prod_n[2*XLEN-1:XLEN] : prod_n[2*XLEN-1:XLEN];
        if (is_div_q) begin
            result = sub_q[1] ? rem : quo;
        end else begin
            result = (sub_q == 2'b00) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
        end
    end

    assign done = (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            prod_q   <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            sub_q    <= 2'b00;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q    <= CW'(XLEN);
            is_div_q <= is_div;
            sub_q    <= sub_op;
            neg_lo_q <= neg_a ^ neg_b;
            neg_hi_q <= neg_a;
            if (is_div) begin
                prod_q <= {{XLEN{1'b0}}, mag_a};
                opnd_q <= mag_b;
            end else begin
                prod_q <= {{XLEN{1'b0}}, mag_b};
                opnd_q <= mag_a;
            end
        end else if (cnt_q != '0) begin
            prod_q <= prod_n;
            cnt_q  <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_iterative.sv
// alu_iterative: handshaked EX-stage ALU. Single-cycle RV32I ALU ops; with
// ALU_MULDIV_EN defined, the RV32M family runs on muldiv_iter (XLEN cycles).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   flush                kill any in-flight or held op; suppresses accept
//   in_valid / in_ready  operand handshake (accept = valid && ready && !flush)
//   alu_op, alu_in_1/2   op code and operands, latched at accept
//   out_valid/out_ready  result handshake; result held until taken
//   alu_result           registered result
//   op_illegal           registered; unknown or disabled op code
// Config macro: ALU_MULDIV_EN enables the MUL/DIV states and datapath.
module alu_iterative
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = calc_shw(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] alu_in_1,
    input  logic [XLEN-1:0] alu_in_2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            op_illegal
);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;

    logic            accept, launch;
    logic            is_simple, is_mul, is_div, div_special;
    logic [XLEN-1:0] simple_res, special_res;
    logic            md_start, md_done;
    logic [XLEN-1:0] md_result;
    logic [SHW-1:0]  shamt;

    assign shamt = alu_in_2[SHW-1:0];

    always_comb begin
        is_simple  = 1'b1;
        simple_res = '0;
        case (alu_op)
            OpAnd:   simple_res = alu_in_1 & alu_in_2;
            OpOr:    simple_res = alu_in_1 | alu_in_2;
            OpAdd:   simple_res = alu_in_1 + alu_in_2;
            OpSub:   simple_res = alu_in_1 - alu_in_2;
            OpXor:   simple_res = alu_in_1 ^ alu_in_2;
            OpSll:   simple_res = alu_in_1 << shamt;
            OpSrl:   simple_res = alu_in_1 >> shamt;
            OpSra:   simple_res = $unsigned($signed(alu_in_1) >>> shamt);
            OpSlt:   simple_res = {{(XLEN-1){1'b0}}, $signed(alu_in_1) < $signed(alu_in_2)};
            OpSltu:  simple_res = {{(XLEN-1){1'b0}}, alu_in_1 < alu_in_2};
            default: is_simple = 1'b0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic div_zero, div_ovf;

    assign is_mul = (alu_op[4:2] == 3'b100);
    assign is_div = (alu_op[4:2] == 3'b101);

    // Divide by zero and signed overflow finish on the single-cycle path.
    assign div_zero    = (alu_in_2 == '0);
    assign div_ovf     = !alu_op[0] && (alu_in_1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                         (alu_in_2 == '1);
    assign div_special = div_zero || div_ovf;

    always_comb begin
        if (div_zero) begin
            special_res = alu_op[1] ? alu_in_1 : '1;
        end else begin
            special_res = alu_op[1] ? '0 : alu_in_1;
        end
    end

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .start  (md_start),
        .is_div (is_div),
        .sub_op (alu_op[1:0]),
        .op_a   (alu_in_1),
        .op_b   (alu_in_2),
        .done   (md_done),
        .result (md_result)
    );
`else
    assign is_mul      = 1'b0;
    assign is_div      = 1'b0;
    assign div_special = 1'b0;
    assign special_res = '0;
    assign md_done     = 1'b0;
    assign md_result   = '0;
`endif

    assign in_ready  = !reset && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state_q == StDone);

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        md_start  = 1'b0;
        launch    = 1'b0;

        case (state_q)
            StIdle: launch = accept;
            StDone: begin
                if (accept) begin
                    launch = 1'b1;
                end else if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                if (md_done) begin
                    state_d   = StDone;
                    result_d  = md_result;
                    illegal_d = 1'b0;
                end
            end
        endcase

        if (launch) begin
            if (is_mul) begin
                state_d  = StMul;
                md_start = 1'b1;
            end else if (is_div && !div_special) begin
                state_d  = StDiv;
                md_start = 1'b1;
            end else begin
                state_d   = StDone;
                result_d  = is_div ? special_res : simple_res;
                illegal_d = !is_simple && !is_div;
            end
        end

        if (flush) begin
            state_d  = StIdle;
            md_start = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign alu_result = result_q;
    assign op_illegal = illegal_q;

endmodule
